// File: rtl/regfile_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arb
// Brief    : Two-requester writeback arbiter with registered regfile write
//            port, pending-write scoreboard and saturating write counter.
//            Define REGFILE_WB_ARB_RR_EN for round-robin arbitration;
//            fixed priority (requester 0 wins) otherwise.
// Revision : 1.0
// ============================================================================
module regfile_wb_arb (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_addr,
    input  logic [31:0] wb0_data,
    output logic        wb0_ready,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_addr,
    input  logic [31:0] wb1_data,
    output logic        wb1_ready,
    output logic        reg_wen,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    input  logic [4:0]  chk_addr_1,
    input  logic [4:0]  chk_addr_2,
    output logic        hazard_1,
    output logic        hazard_2,
    output logic [15:0] wr_cnt
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [31:0] r_pending;
    logic        w_pick0;
    logic        w_hs;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        w_write;
    logic [31:0] w_clr;
    logic [31:0] w_set;

`ifdef REGFILE_WB_ARB_RR_EN
    logic r_last_grant;

    // Requester 0 is favoured whenever requester 1 won last time.
    assign w_pick0 = r_last_grant;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_last_grant <= 1'b1;
        end else if (w_hs) begin
            r_last_grant <= wb1_ready;
        end
    end
`else
    assign w_pick0 = 1'b1;
`endif

    // Ready is gated by hrstn so nothing is granted while reset is asserted.
    assign wb0_ready = hrstn & wb0_valid & (~wb1_valid | w_pick0);
    assign wb1_ready = hrstn & wb1_valid & ~(wb0_valid & w_pick0);

    assign w_hs    = wb0_ready | wb1_ready;
    assign w_addr  = wb1_ready ? wb1_addr : wb0_addr;
    assign w_data  = wb1_ready ? wb1_data : wb0_data;
    assign w_write = w_hs & (w_addr != 5'd0);

    // Set after clear so a same-cycle reservation survives the writeback.
    assign w_clr = w_hs ? (32'd1 << w_addr) : 32'd0;
    assign w_set = (rsv_valid && (rsv_addr != 5'd0)) ? (32'd1 << rsv_addr) : 32'd0;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            reg_wen   <= 1'b0;
            reg_waddr <= 5'd0;
            reg_wdata <= 32'd0;
            r_pending <= 32'd0;
            wr_cnt    <= 16'd0;
        end else begin
            reg_wen   <= w_write;
            r_pending <= (r_pending & ~w_clr) | w_set;
            if (w_write) begin
                reg_waddr <= w_addr;
                reg_wdata <= w_data;
                if (wr_cnt != c_CNT_MAX) begin
                    wr_cnt <= wr_cnt + 16'd1;
                end
            end
        end
    end

    assign hazard_1 = hrstn & (chk_addr_1 != 5'd0) & r_pending[chk_addr_1];
    assign hazard_2 = hrstn & (chk_addr_2 != 5'd0) & r_pending[chk_addr_2];

endmodule
`default_nettype wire

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: hclk is the single clock and hrstn the asynchronous active-low reset; all state SHALL be in the hclk domain.
REQ-002 Port: hclk  in  1  clock.
REQ-003 Port: hrstn  in  1  async active-low reset.
REQ-004 Ports: wb0_valid in 1, wb0_addr in 5, wb0_data in 32  requester 0 (ALU writeback) write request.
REQ-005 Port: wb0_ready  out  1  requester 0 accept, combinational.
REQ-006 Ports: wb1_valid in 1, wb1_addr in 5, wb1_data in 32  requester 1 (LSU load writeback) write request.
REQ-007 Port: wb1_ready  out  1  requester 1 accept, combinational.
REQ-008 Ports: reg_wen out 1, reg_waddr out 5, reg_wdata out 32  registered regfile write port.
REQ-009 Ports: rsv_valid in 1, rsv_addr in 5  destination reservation at issue.
REQ-010 Ports: chk_addr_1 in 5, chk_addr_2 in 5  source operand addresses.
REQ-011 Ports: hazard_1 out 1, hazard_2 out 1  pending-write flags, combinational.
REQ-012 Port: wr_cnt  out  16  count of committed regfile writes, saturating.

Function
REQ-013 SHALL complete a handshake on requester n when wbn_valid and wbn_ready are both 1 at a rising edge of hclk.
REQ-014 SHALL assert at most one of wb0_ready or wb1_ready in any cycle; a lone valid requester SHALL be granted in the same cycle.
REQ-015 Requesters SHALL hold valid, addr and data stable until accepted; the arbiter SHALL NOT drop or reorder accepted requests.
REQ-016 When both valids are 1, arbitration SHALL follow REQ-029/REQ-030; last_grant SHALL update to the winner on each handshake.
REQ-017 On a handshake, reg_wen, reg_waddr and reg_wdata SHALL present the winner's write on the next cycle, giving one-cycle latency; with no handshake, reg_wen SHALL be 0 and addr/data SHALL hold their previous values.
REQ-018 A handshake with addr 0 SHALL be accepted, SHALL keep reg_wen at 0, and SHALL NOT increment wr_cnt.
REQ-019 Scoreboard: pending[31:0]; rsv_valid with rsv_addr!=0 SHALL set pending[rsv_addr] at the edge.
REQ-020 A handshake to address a SHALL clear pending[a] at the same edge that registers reg_wen.
REQ-021 If a set and a clear target the same address in one cycle, the set SHALL win and the bit SHALL remain 1.
REQ-022 hazard_k SHALL equal pending[chk_addr_k] when chk_addr_k!=0, and SHALL be 0 for address 0.
REQ-023 wr_cnt SHALL increment on each cycle with reg_wen=1 and SHALL saturate at 0xFFFF.

Reset
REQ-024 hrstn low SHALL, asynchronously, force reg_wen=0, reg_waddr=0, reg_wdata=0, pending=0, wr_cnt=0 and last_grant=1.
REQ-025 While hrstn is low, wb0_ready, wb1_ready, hazard_1 and hazard_2 SHALL be 0.
REQ-026 Reset mid-transfer SHALL discard any in-flight write; the write SHALL NOT reappear after reset release.
REQ-027 The first arbitration after reset SHALL favour requester 0.

Configuration
REQ-028 Macro REGFILE_WB_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 With REGFILE_WB_ARB_RR_EN defined, contention SHALL grant the requester that is not last_grant (round-robin).
REQ-030 With REGFILE_WB_ARB_RR_EN undefined, contention SHALL always grant requester 0 (fixed priority), and last_grant SHALL be unused.

Verification
REQ-031 Lone write: wb0 valid, addr 5, data 0xDEADBEEF -> wb0_ready=1 same cycle; next cycle reg_wen=1, reg_waddr=5, reg_wdata=0xDEADBEEF; wr_cnt=1.
REQ-032 Contention held 4 cycles, addrs 3 and 7 -> RR build: grants 0,1,0,1; fixed-priority build: wb0 granted every cycle and wb1_ready=0 throughout.
REQ-033 rsv addr 9, then chk_addr_1=9 -> hazard_1=1 until the cycle after the wb handshake to 9; simultaneous rsv 9 and write 9 -> hazard stays 1.
REQ-034 Write to x0 with data 0x1234 -> ready=1, reg_wen stays 0, wr_cnt unchanged; rsv_addr 0 -> hazard_1=0 with chk_addr_1=0.
REQ-035 Preload wr_cnt to 0xFFFE, issue 3 writes -> wr_cnt=0xFFFF.
REQ-036 Assert hrstn low mid-contention with pending=0x00000280 -> all outputs 0 immediately; after release, wb0 wins the first contention.
